// File: rtl/apb_mem_slave_param.sv
// APB slave with a word-addressed byte-strobed register memory. Latency: 1 + WAIT_STATES cycles from setup to completion.
// Backpressure: p_ready is held low for WAIT_STATES access cycles. Out-of-range and setup-less accesses complete with p_slverr.
module apb_mem_slave_param #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                    p_clk,
  input  logic                    p_reset,
  input  logic                    p_sel,
  input  logic                    p_enable,
  input  logic                    p_write,
  input  logic [ADDR_WIDTH-1:0]   p_add,
  input  logic [DATA_WIDTH-1:0]   p_wdata,
  input  logic [DATA_WIDTH/8-1:0] p_strb,
  output logic [DATA_WIDTH-1:0]   p_rdata,
  output logic                    p_ready,
  output logic                    p_slverr,
  output logic [1:0]              ns
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(NBYTES);
  localparam int IDX_W  = ADDR_WIDTH - OFF_W;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CMP_W  = IDX_W + 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [3:0]            wcnt_q;
  logic [MEM_AW-1:0]     idx_q;
  logic                  wr_q;
  logic                  oor_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [IDX_W-1:0]      idx;
  logic [MEM_AW-1:0]     mem_idx;
  logic                  oor;
  logic                  setup_edge;
  logic                  proto_err;
  logic                  legal;
  logic                  done;
  logic                  commit;
  logic                  wait_zero;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  unused_lsbs;

  assign idx     = p_add[ADDR_WIDTH-1:OFF_W];
  assign mem_idx = idx[MEM_AW-1:0];
  // Wide compare so that large indices never alias back into range.
  assign oor     = CMP_W'(idx) >= CMP_W'(DEPTH);

  generate
    if (OFF_W > 0) begin : g_lsbs
      assign unused_lsbs = ^p_add[(OFF_W > 0 ? OFF_W - 1 : 0):0];
    end else begin : g_no_lsbs
      assign unused_lsbs = 1'b0;
    end
  endgenerate

  assign setup_edge = p_sel & ~p_enable;
  assign wait_zero  = (wcnt_q == 4'd0);
  assign rd_word    = oor ? '0 : mem[mem_idx];
  assign ns         = state_q;

  always_comb begin
    proto_err = 1'b0;
    legal     = 1'b0;
    done      = 1'b0;
    commit    = 1'b0;
    p_ready   = 1'b0;
    p_slverr  = 1'b0;
    state_d   = ST_IDLE;

    if (p_sel && p_enable) begin
      if (state_q == ST_SETUP || state_q == ST_ACCESS) begin
        legal = 1'b1;
      end else begin
        proto_err = 1'b1;
      end
    end
    done   = legal & wait_zero;
    commit = done & wr_q & ~oor_q;

    // Outputs are forced low while reset is held, whatever the bus does.
    p_ready  = p_reset & (proto_err | done);
    p_slverr = p_reset & (proto_err | (done & oor_q));

    if (setup_edge) begin
      state_d = ST_SETUP;
    end else if (p_sel && p_enable && !p_ready) begin
      state_d = ST_ACCESS;
    end
  end

  always_ff @(posedge p_clk or negedge p_reset) begin
    if (!p_reset) begin
      state_q <= ST_IDLE;
      wcnt_q  <= 4'd0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      oor_q   <= 1'b0;
      p_rdata <= '0;
    end else begin
      state_q <= state_d;
      if (setup_edge) begin
        idx_q  <= mem_idx;
        wr_q   <= p_write;
        oor_q  <= oor;
        wcnt_q <= 4'(WAIT_STATES);
        if (!p_write) begin
          p_rdata <= rd_word;
        end
      end else if (legal && !wait_zero) begin
        wcnt_q <= wcnt_q - 4'd1;
      end else if (!p_sel) begin
        wcnt_q <= 4'd0;
      end
    end
  end

  // Write data and strobes are taken on the completion edge, not at setup.
  always_ff @(posedge p_clk or negedge p_reset) begin
    if (!p_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (commit) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (p_strb[b]) begin
          mem[idx_q][8*b +: 8] <= p_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_mem_slave_param.sv
// Self-checking bench for apb_mem_slave_param: vector table, corner sequences and randomized traffic against a memory model.
module tb_apb_mem_slave_param;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 16;
  localparam int WS    = 2;

  logic          p_clk = 1'b0;
  logic          p_reset;
  logic          p_sel;
  logic          p_enable;
  logic          p_write;
  logic [AW-1:0] p_add;
  logic [DW-1:0] p_wdata;
  logic [3:0]    p_strb;
  logic [DW-1:0] p_rdata;
  logic          p_ready;
  logic          p_slverr;
  logic [1:0]    ns;

  apb_mem_slave_param #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .WAIT_STATES(WS)
  ) dut (
    .p_clk   (p_clk),
    .p_reset (p_reset),
    .p_sel   (p_sel),
    .p_enable(p_enable),
    .p_write (p_write),
    .p_add   (p_add),
    .p_wdata (p_wdata),
    .p_strb  (p_strb),
    .p_rdata (p_rdata),
    .p_ready (p_ready),
    .p_slverr(p_slverr),
    .ns      (ns)
  );

  always #5 p_clk = ~p_clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] model_mem [DEPTH];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic bit model_oor(input logic [31:0] addr);
    return (addr / 4) >= DEPTH;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    if (model_oor(addr)) return 32'h0;
    return model_mem[addr / 4];
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    if (!model_oor(addr)) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) model_mem[addr / 4][8*b +: 8] = data[8*b +: 8];
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
  endtask

  // Entered and left at 1 time unit after a rising edge, with p_sel still high.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, output logic [31:0] rdata,
                      output logic err, output int waits);
    p_sel    = 1'b1;
    p_enable = 1'b0;
    p_write  = wr;
    p_add    = addr;
    p_wdata  = data;
    p_strb   = strb;
    @(posedge p_clk); #1;
    p_enable = 1'b1;
    waits    = 0;
    forever begin
      @(negedge p_clk);
      if (p_ready === 1'b1) break;
      waits++;
      if (waits > 40) begin
        check("xfer_timeout", 64'(waits), 64'(WS));
        break;
      end
      @(posedge p_clk); #1;
    end
    rdata = p_rdata;
    err   = p_slverr;
    @(posedge p_clk); #1;
  endtask

  task automatic idle_cycle();
    p_sel    = 1'b0;
    p_enable = 1'b0;
    @(posedge p_clk); #1;
  endtask

  // Issues one transfer and checks it against the model, then updates the model.
  task automatic model_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input string name);
    logic [31:0] rd;
    logic        err;
    int          waits;
    logic [31:0] exp_rd;
    bit          exp_err;
    exp_rd  = model_read(addr);
    exp_err = model_oor(addr);
    xfer(wr, addr, data, strb, rd, err, waits);
    check({name, "_err"}, 64'(err), 64'(exp_err));
    check({name, "_waits"}, 64'(waits), 64'(WS));
    if (!wr) check({name, "_rdata"}, 64'(rd), 64'(exp_rd));
    else model_write(addr, data, strb);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  ns_seq [8];
    logic [31:0] rd;
    logic        err;
    int          waits;
    int          k;
    logic [31:0] a;

    vecs[0]  = '{1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h04, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h04, 32'h12345678, 4'h3, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 32'h04, 32'h0,        4'h0, 32'hDEAD5678, 1'b0};
    vecs[4]  = '{1'b1, 32'h06, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
    vecs[5]  = '{1'b0, 32'h04, 32'h0,        4'h0, 32'hDEAD5678, 1'b0};
    vecs[6]  = '{1'b1, 32'h40, 32'h11111111, 4'hF, 32'h0,        1'b1};
    vecs[7]  = '{1'b0, 32'h40, 32'h0,        4'h0, 32'h0,        1'b1};
    vecs[8]  = '{1'b0, 32'h00, 32'h0,        4'h0, 32'h0,        1'b0};
    vecs[9]  = '{1'b1, 32'h3C, 32'h0BADF00D, 4'hC, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 32'h3F, 32'h0,        4'h0, 32'h0BAD0000, 1'b0};
    vecs[11] = '{1'b0, 32'h04, 32'h0,        4'h0, 32'hDEAD5678, 1'b0};

    model_clear();
    p_reset  = 1'b0;
    p_sel    = 1'b0;
    p_enable = 1'b0;
    p_write  = 1'b0;
    p_add    = '0;
    p_wdata  = '0;
    p_strb   = '0;

    // Reset: outputs stay quiet even with a bus access being driven.
    repeat (2) @(posedge p_clk);
    #1;
    p_sel    = 1'b1;
    p_enable = 1'b1;
    @(negedge p_clk);
    check("rst_ready", 64'(p_ready), 64'd0);
    check("rst_slverr", 64'(p_slverr), 64'd0);
    check("rst_ns", 64'(ns), 64'd0);
    check("rst_rdata", 64'(p_rdata), 64'd0);
    p_sel    = 1'b0;
    p_enable = 1'b0;
    p_reset  = 1'b1;
    @(posedge p_clk); #1;

    // Phase sequence of a read at 0x8.
    p_sel    = 1'b1;
    p_enable = 1'b0;
    p_write  = 1'b0;
    p_add    = 32'h8;
    @(negedge p_clk);
    ns_seq[0] = ns;
    @(posedge p_clk); #1;
    p_enable = 1'b1;
    k   = 1;
    rd  = 32'hFFFFFFFF;
    err = 1'b1;
    while (k < 7) begin
      @(negedge p_clk);
      ns_seq[k] = ns;
      k++;
      if (p_ready === 1'b1) begin
        rd  = p_rdata;
        err = p_slverr;
        break;
      end
      @(posedge p_clk); #1;
    end
    @(posedge p_clk); #1;
    p_sel    = 1'b0;
    p_enable = 1'b0;
    @(negedge p_clk);
    ns_seq[k] = ns;
    check("t1_len", 64'(k), 64'd4);
    check("t1_ns0", 64'(ns_seq[0]), 64'd0);
    check("t1_ns1", 64'(ns_seq[1]), 64'd1);
    check("t1_ns2", 64'(ns_seq[2]), 64'd2);
    check("t1_ns3", 64'(ns_seq[3]), 64'd2);
    check("t1_ns4", 64'(ns_seq[4]), 64'd0);
    check("t1_rdata", 64'(rd), 64'd0);
    check("t1_err", 64'(err), 64'd0);
    @(posedge p_clk); #1;

    // Directed vector table.
    for (int i = 0; i < 12; i++) begin
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, err, waits);
      check($sformatf("vec%0d_err", i), 64'(err), 64'(vecs[i].exp_err));
      check($sformatf("vec%0d_waits", i), 64'(waits), 64'(WS));
      if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rdata));
      else model_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb);
    end

    // Access phase with no preceding setup.
    p_sel    = 1'b1;
    p_enable = 1'b1;
    p_write  = 1'b1;
    p_add    = 32'h0;
    p_wdata  = 32'hFFFFFFFF;
    p_strb   = 4'hF;
    @(negedge p_clk);
    check("perr_ready", 64'(p_ready), 64'd1);
    check("perr_slverr", 64'(p_slverr), 64'd1);
    @(posedge p_clk); #1;
    p_sel    = 1'b0;
    p_enable = 1'b0;
    @(negedge p_clk);
    check("perr_ns", 64'(ns), 64'd0);
    check("perr_rdata_held", 64'(p_rdata), 64'hDEAD5678);
    @(posedge p_clk); #1;
    model_xfer(1'b0, 32'h0, 32'h0, 4'h0, "perr_read0");
    idle_cycle();

    // Reset pulled during the first access cycle of a write to 0xC.
    p_sel    = 1'b1;
    p_enable = 1'b0;
    p_write  = 1'b1;
    p_add    = 32'hC;
    p_wdata  = 32'hCAFEF00D;
    p_strb   = 4'hF;
    @(posedge p_clk); #1;
    p_enable = 1'b1;
    @(negedge p_clk);
    check("mrst_acc1_ready", 64'(p_ready), 64'd0);
    #1;
    p_reset = 1'b0;
    #1;
    check("mrst_ns", 64'(ns), 64'd0);
    check("mrst_ready", 64'(p_ready), 64'd0);
    check("mrst_slverr", 64'(p_slverr), 64'd0);
    check("mrst_rdata", 64'(p_rdata), 64'd0);
    model_clear();
    @(posedge p_clk);
    @(negedge p_clk);
    p_reset  = 1'b1;
    p_sel    = 1'b0;
    p_enable = 1'b0;
    @(posedge p_clk); #1;
    model_xfer(1'b0, 32'hC, 32'h0, 4'h0, "mrst_readC");

    // Back-to-back reads with no idle cycle between them.
    model_xfer(1'b1, 32'h0, 32'hA5A5C3C3, 4'hF, "b2b_w0");
    model_xfer(1'b1, 32'h4, 32'h5A5A3C3C, 4'hF, "b2b_w1");
    model_xfer(1'b0, 32'h0, 32'h0, 4'h0, "b2b_r0");
    model_xfer(1'b0, 32'h4, 32'h0, 4'h0, "b2b_r1");
    idle_cycle();

    // Randomized traffic, including out-of-range indices and ignored offset bits.
    for (int n = 0; n < 150; n++) begin
      a = (32'($urandom_range(0, 19)) << 2) | 32'($urandom_range(0, 3));
      model_xfer(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), "rnd");
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    for (int i = 0; i < DEPTH; i++) begin
      model_xfer(1'b0, 32'(i * 4), 32'h0, 4'h0, $sformatf("sweep%0d", i));
    end
    idle_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
